// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types and helpers for the byte-enable clearable dual-port RAM
package dpram_pkg;

  localparam int FILL_MAX = 256;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_RUN   = 1'b1
  } clr_state_t;

  function automatic int nb(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Replicates one bit over the low 'width' bits; callers slice to their word width.
  function automatic logic [FILL_MAX-1:0] fill(input logic b, input int width);
    logic [FILL_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < FILL_MAX; i++) begin
      if (i < width) r[i] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_be_clr_if.sv
// rtl/dpram_be_clr_if.sv - two-port RAM bus plus clear/status signals
interface dpram_be_clr_if #(
  parameter int addr_width = 8,
  parameter int data_width = 16,
  parameter int byte_width = 8
);
  import dpram_pkg::*;

  localparam int NB = nb(data_width, byte_width);

  logic                  clear_req;
  logic                  busy;
  logic                  collision;

  logic [addr_width-1:0] address_a;
  logic [data_width-1:0] data_a;
  logic [NB-1:0]         byteena_a;
  logic                  enable_a;
  logic                  wren_a;
  logic                  cs_a;
  logic [data_width-1:0] q_a;

  logic [addr_width-1:0] address_b;
  logic [data_width-1:0] data_b;
  logic [NB-1:0]         byteena_b;
  logic                  enable_b;
  logic                  wren_b;
  logic                  cs_b;
  logic [data_width-1:0] q_b;

  modport master (
    output clear_req,
    output address_a, data_a, byteena_a, enable_a, wren_a, cs_a,
    output address_b, data_b, byteena_b, enable_b, wren_b, cs_b,
    input  busy, collision, q_a, q_b
  );

  modport slave (
    input  clear_req,
    input  address_a, data_a, byteena_a, enable_a, wren_a, cs_a,
    input  address_b, data_b, byteena_b, enable_b, wren_b, cs_b,
    output busy, collision, q_a, q_b
  );

endinterface

// File: rtl/dpram_be_core.sv
// rtl/dpram_be_core.sv - byte-lane true dual-port array with registered reads
module dpram_be_core
  import dpram_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 16,
  parameter int byte_width = 8
) (
  input  logic                                  i_clk,
  input  logic [addr_width-1:0]                 i_addr_a,
  input  logic [data_width-1:0]                 i_wdata_a,
  input  logic [nb(data_width, byte_width)-1:0] i_we_a,
  input  logic                                  i_re_a,
  output logic [data_width-1:0]                 o_q_a,
  input  logic [addr_width-1:0]                 i_addr_b,
  input  logic [data_width-1:0]                 i_wdata_b,
  input  logic [nb(data_width, byte_width)-1:0] i_we_b,
  input  logic                                  i_re_b,
  output logic [data_width-1:0]                 o_q_b
);

  localparam int NB    = nb(data_width, byte_width);
  localparam int DEPTH = 1 << addr_width;

  logic [data_width-1:0] r_mem [0:DEPTH-1];
  logic [data_width-1:0] r_q_a;
  logic [data_width-1:0] r_q_b;

  // Same-port read-during-write: written lanes take new data, others keep old contents.
  function automatic logic [data_width-1:0] merge(input logic [data_width-1:0] old_w,
                                                  input logic [data_width-1:0] new_w,
                                                  input logic [NB-1:0]         we);
    logic [data_width-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) r[i*byte_width +: byte_width] = new_w[i*byte_width +: byte_width];
    end
    return r;
  endfunction

  // Port A lane writes come last so A wins overlapping lanes on a shared address.
  always_ff @(posedge i_clk) begin
    if (i_re_a) r_q_a <= merge(r_mem[i_addr_a], i_wdata_a, i_we_a);
    if (i_re_b) r_q_b <= merge(r_mem[i_addr_b], i_wdata_b, i_we_b);
    for (int i = 0; i < NB; i++) begin
      if (i_we_b[i]) r_mem[i_addr_b][i*byte_width +: byte_width] <= i_wdata_b[i*byte_width +: byte_width];
      if (i_we_a[i]) r_mem[i_addr_a][i*byte_width +: byte_width] <= i_wdata_a[i*byte_width +: byte_width];
    end
  end

  assign o_q_a = r_q_a;
  assign o_q_b = r_q_b;

endmodule

// File: rtl/dpram_be_clr.sv
// rtl/dpram_be_clr.sv - dual-port RAM with byte enables, cs-gated outputs and clear sequencer
module dpram_be_clr
  import dpram_pkg::*;
#(
  parameter int addr_width     = 8,
  parameter int data_width     = 16,
  parameter int byte_width     = 8,
  parameter int out_reg        = 0,
  parameter bit disable_value  = 1'b1,
  parameter bit clear_value    = 1'b0,
  parameter int clear_on_reset = 1
) (
  input  logic           clock,
  input  logic           reset,
  dpram_be_clr_if.slave  bus
);

  localparam int NB = nb(data_width, byte_width);
  localparam logic [FILL_MAX-1:0]   DIS_W   = fill(disable_value, data_width);
  localparam logic [FILL_MAX-1:0]   CLR_W   = fill(clear_value, data_width);
  localparam logic [data_width-1:0] DIS_PAT = DIS_W[data_width-1:0];
  localparam logic [data_width-1:0] CLR_PAT = CLR_W[data_width-1:0];

  if (data_width % byte_width != 0) begin : g_width_chk
    $error("dpram_be_clr: data_width must be a multiple of byte_width");
  end

  clr_state_t            r_state;
  clr_state_t            w_state_nxt;
  logic [addr_width-1:0] r_cnt;
  logic [addr_width-1:0] w_cnt_nxt;
  logic                  w_run;
  logic                  w_acc_a;
  logic                  w_acc_b;
  logic [NB-1:0]         w_we_a;
  logic [NB-1:0]         w_we_b;
  logic [addr_width-1:0] w_addr_a;
  logic [data_width-1:0] w_wdata_a;
  logic [data_width-1:0] w_raw_a;
  logic [data_width-1:0] w_raw_b;
  logic                  w_coll;
  logic                  r_collision;
  logic                  r_v_a1;
  logic                  r_v_b1;

  assign w_run    = (r_state == CLR_RUN);
  assign bus.busy = ~w_run;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= (clear_on_reset != 0) ? CLR_CLEAR : CLR_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLR_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) w_state_nxt = CLR_RUN;
      end
      CLR_RUN: begin
        if (bus.clear_req) begin
          w_state_nxt = CLR_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = CLR_RUN;
    endcase
  end

  // The clear sequencer borrows port A; user traffic is dropped while busy.
  assign w_acc_a   = w_run & bus.enable_a & bus.cs_a;
  assign w_acc_b   = w_run & bus.enable_b & bus.cs_b;
  assign w_we_a    = !w_run ? {NB{1'b1}} : ((w_acc_a & bus.wren_a) ? bus.byteena_a : '0);
  assign w_we_b    = (w_acc_b & bus.wren_b) ? bus.byteena_b : '0;
  assign w_addr_a  = w_run ? bus.address_a : r_cnt;
  assign w_wdata_a = w_run ? bus.data_a : CLR_PAT;
  assign w_coll    = w_acc_a & w_acc_b & bus.wren_a & bus.wren_b &
                     (bus.address_a == bus.address_b) & (|(bus.byteena_a & bus.byteena_b));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_collision <= 1'b0;
      r_v_a1      <= 1'b0;
      r_v_b1      <= 1'b0;
    end else begin
      r_collision <= w_coll;
      if (!w_run) begin
        r_v_a1 <= 1'b0;
        r_v_b1 <= 1'b0;
      end else begin
        if (bus.enable_a) r_v_a1 <= bus.cs_a;
        if (bus.enable_b) r_v_b1 <= bus.cs_b;
      end
    end
  end

  assign bus.collision = r_collision;

  dpram_be_core #(
    .addr_width (addr_width),
    .data_width (data_width),
    .byte_width (byte_width)
  ) u_core (
    .i_clk     (clock),
    .i_addr_a  (w_addr_a),
    .i_wdata_a (w_wdata_a),
    .i_we_a    (w_we_a),
    .i_re_a    (w_acc_a),
    .o_q_a     (w_raw_a),
    .i_addr_b  (bus.address_b),
    .i_wdata_b (bus.data_b),
    .i_we_b    (w_we_b),
    .i_re_b    (w_acc_b),
    .o_q_b     (w_raw_b)
  );

  // The cs bit travels with the read data so gating lines up with the latency.
  if (out_reg != 0) begin : g_oreg
    logic                  r_v_a2;
    logic                  r_v_b2;
    logic [data_width-1:0] r_q_a2;
    logic [data_width-1:0] r_q_b2;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_v_a2 <= 1'b0;
        r_v_b2 <= 1'b0;
      end else if (!w_run) begin
        r_v_a2 <= 1'b0;
        r_v_b2 <= 1'b0;
      end else begin
        if (bus.enable_a) r_v_a2 <= r_v_a1;
        if (bus.enable_b) r_v_b2 <= r_v_b1;
      end
    end

    always_ff @(posedge clock) begin
      if (w_run & bus.enable_a) r_q_a2 <= w_raw_a;
      if (w_run & bus.enable_b) r_q_b2 <= w_raw_b;
    end

    assign bus.q_a = (w_run & r_v_a2) ? r_q_a2 : DIS_PAT;
    assign bus.q_b = (w_run & r_v_b2) ? r_q_b2 : DIS_PAT;
  end else begin : g_noreg
    assign bus.q_a = (w_run & r_v_a1) ? w_raw_a : DIS_PAT;
    assign bus.q_b = (w_run & r_v_b1) ? w_raw_b : DIS_PAT;
  end

endmodule

// File: tb/tb_dpram_be_clr.sv
// tb/tb_dpram_be_clr.sv - scoreboard bench for dpram_be_clr (latency-1 and latency-2 instances)
module tb_dpram_be_clr;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int BW = 8;

  localparam int S_QA   = 0;
  localparam int S_QB   = 1;
  localparam int S_QA2  = 2;
  localparam int S_BUSY = 3;
  localparam int S_COLL = 4;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] exp;
    string       name;
  } chk_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  chk_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dpram_be_clr_if #(.addr_width(AW), .data_width(DW), .byte_width(BW)) bus1 ();
  dpram_be_clr_if #(.addr_width(AW), .data_width(DW), .byte_width(BW)) bus2 ();

  dpram_be_clr #(
    .addr_width(AW), .data_width(DW), .byte_width(BW), .out_reg(0),
    .disable_value(1'b1), .clear_value(1'b0), .clear_on_reset(1)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  dpram_be_clr #(
    .addr_width(AW), .data_width(DW), .byte_width(BW), .out_reg(1),
    .disable_value(1'b1), .clear_value(1'b0), .clear_on_reset(1)
  ) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_QA:    return bus1.q_a;
      S_QB:    return bus1.q_b;
      S_QA2:   return bus2.q_a;
      S_BUSY:  return {15'd0, bus1.busy};
      default: return {15'd0, bus1.collision};
    endcase
  endfunction

  task automatic expect_at(input int sel, input int lat, input logic [15:0] v, input string nm);
    chk_t c;
    c.due  = cyc + lat;
    c.sel  = sel;
    c.exp  = v;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic set_a(input logic en, input logic cs, input logic wr,
                       input logic [3:0] addr, input logic [15:0] d, input logic [1:0] be);
    bus1.enable_a = en; bus1.cs_a = cs; bus1.wren_a = wr;
    bus1.address_a = addr; bus1.data_a = d; bus1.byteena_a = be;
    bus2.enable_a = en; bus2.cs_a = cs; bus2.wren_a = wr;
    bus2.address_a = addr; bus2.data_a = d; bus2.byteena_a = be;
  endtask

  task automatic set_b(input logic en, input logic cs, input logic wr,
                       input logic [3:0] addr, input logic [15:0] d, input logic [1:0] be);
    bus1.enable_b = en; bus1.cs_b = cs; bus1.wren_b = wr;
    bus1.address_b = addr; bus1.data_b = d; bus1.byteena_b = be;
  endtask

  task automatic set_clr(input logic v);
    bus1.clear_req = v;
    bus2.clear_req = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin : monitor
    int          i;
    logic [15:0] act;
    forever begin
      @(negedge clock);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].due == cyc) begin
          act = observe(sb[i].sel);
          n_chk++;
          if (act === sb[i].exp) n_pass++;
          else $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    set_clr(1'b0);
    set_a(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    set_b(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    bus2.enable_b = 1'b0; bus2.cs_b = 1'b0; bus2.wren_b = 1'b0;
    bus2.address_b = '0; bus2.data_b = '0; bus2.byteena_b = '0;
    reset = 1'b1;
    step(3);

    reset = 1'b0;
    expect_at(S_BUSY, 1, 16'h0001, "busy_start");
    expect_at(S_QA, 5, 16'hFFFF, "qa_during_busy");
    expect_at(S_QB, 5, 16'hFFFF, "qb_during_busy");
    expect_at(S_QA2, 5, 16'hFFFF, "qa2_during_busy");
    expect_at(S_BUSY, 15, 16'h0001, "busy_last");
    expect_at(S_BUSY, 16, 16'h0000, "busy_fall");
    step(16);
    n_chk++;
    if (bus1.busy === 1'b0) n_pass++;
    else $display("FAIL direct_busy_low: got %b", bus1.busy);
    n_chk++;
    if (bus2.busy === 1'b0) n_pass++;
    else $display("FAIL direct_busy2_low: got %b", bus2.busy);

    for (int a = 0; a < 16; a++) begin
      set_a(1'b1, 1'b1, 1'b0, a[3:0], 16'h0, 2'b00);
      set_b(1'b1, 1'b1, 1'b0, 4'(15 - a), 16'h0, 2'b00);
      expect_at(S_QA, 1, 16'h0000, "clear_read_a");
      expect_at(S_QB, 1, 16'h0000, "clear_read_b");
      expect_at(S_QA2, 2, 16'h0000, "clear_read_a_lat2");
      step(1);
    end
    set_a(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    set_b(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    step(2);

    set_a(1'b1, 1'b1, 1'b1, 4'd3, 16'h1234, 2'b11);
    step(1);
    set_a(1'b1, 1'b1, 1'b1, 4'd3, 16'hAB00, 2'b10);
    expect_at(S_QA, 1, 16'hAB34, "rdw_same_port");
    step(1);
    set_a(1'b1, 1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
    expect_at(S_QA, 1, 16'hAB34, "byte_write_lat1");
    expect_at(S_QA2, 2, 16'hAB34, "byte_write_lat2");
    step(1);
    set_a(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    step(2);

    set_a(1'b1, 1'b1, 1'b1, 4'd5, 16'h1111, 2'b01);
    set_b(1'b1, 1'b1, 1'b1, 4'd5, 16'h2222, 2'b10);
    expect_at(S_COLL, 1, 16'h0000, "no_collision");
    step(1);
    set_a(1'b1, 1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
    set_b(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    expect_at(S_QA, 1, 16'h2211, "dual_write_disjoint");
    step(1);

    set_a(1'b1, 1'b1, 1'b1, 4'd5, 16'h1111, 2'b11);
    set_b(1'b1, 1'b1, 1'b1, 4'd5, 16'h2222, 2'b10);
    expect_at(S_COLL, 1, 16'h0001, "collision_pulse");
    expect_at(S_COLL, 2, 16'h0000, "collision_one_cycle");
    step(1);
    n_chk++;
    if (bus1.collision === 1'b1) n_pass++;
    else $display("FAIL direct_collision: got %b", bus1.collision);
    set_a(1'b1, 1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
    set_b(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    expect_at(S_QA, 1, 16'h1111, "dual_write_a_wins");
    step(1);

    set_a(1'b1, 1'b1, 1'b1, 4'd7, 16'h5555, 2'b11);
    set_b(1'b1, 1'b1, 1'b0, 4'd7, 16'h0, 2'b00);
    expect_at(S_QB, 1, 16'h0000, "cross_read_old");
    step(1);
    n_chk++;
    if (bus1.q_b === 16'h0000) n_pass++;
    else $display("FAIL direct_cross_read_old: got %h", bus1.q_b);
    set_a(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    expect_at(S_QB, 1, 16'h5555, "cross_read_new");
    step(1);

    set_b(1'b1, 1'b0, 1'b0, 4'd3, 16'h0, 2'b00);
    expect_at(S_QB, 1, 16'hFFFF, "cs_low_disabled");
    step(1);
    set_b(1'b1, 1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
    expect_at(S_QB, 1, 16'hAB34, "cs_high_read");
    step(1);
    set_b(1'b0, 1'b1, 1'b0, 4'd7, 16'h0, 2'b00);
    expect_at(S_QB, 1, 16'hAB34, "enable_hold_1");
    expect_at(S_QB, 2, 16'hAB34, "enable_hold_2");
    expect_at(S_QB, 3, 16'hAB34, "enable_hold_3");
    step(3);

    set_clr(1'b1);
    expect_at(S_BUSY, 1, 16'h0001, "clear_req_busy");
    step(1);
    set_clr(1'b0);
    step(3);
    set_clr(1'b1);
    set_a(1'b1, 1'b1, 1'b1, 4'd9, 16'h1234, 2'b11);
    set_b(1'b1, 1'b1, 1'b1, 4'd9, 16'h5678, 2'b11);
    expect_at(S_COLL, 1, 16'h0000, "busy_write_no_collision");
    expect_at(S_QA, 1, 16'hFFFF, "busy_qa_disabled");
    expect_at(S_QB, 1, 16'hFFFF, "busy_qb_disabled");
    expect_at(S_BUSY, 1, 16'h0001, "busy_mid_clear");
    step(1);
    set_clr(1'b0);
    set_a(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    set_b(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_at(S_BUSY, 1, 16'h0001, "restart_busy_start");
    expect_at(S_BUSY, 15, 16'h0001, "restart_busy_last");
    expect_at(S_BUSY, 16, 16'h0000, "restart_busy_fall");
    step(16);
    n_chk++;
    if (bus1.busy === 1'b0) n_pass++;
    else $display("FAIL direct_restart_busy_low: got %b", bus1.busy);

    for (int a = 0; a < 16; a++) begin
      set_a(1'b1, 1'b1, 1'b0, a[3:0], 16'h0, 2'b00);
      set_b(1'b1, 1'b1, 1'b0, 4'(15 - a), 16'h0, 2'b00);
      expect_at(S_QA, 1, 16'h0000, "reclear_read_a");
      expect_at(S_QB, 1, 16'h0000, "reclear_read_b");
      expect_at(S_QA2, 2, 16'h0000, "reclear_read_a_lat2");
      step(1);
    end
    set_a(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    set_b(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    step(4);

    foreach (sb[i]) begin
      n_chk++;
      $display("FAIL %s: never sampled (due cycle %0d)", sb[i].name, sb[i].due);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
